// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic pipeline stage with valid/ready handshake and sync flush.
// Optional skid entry under macro PIPE_STAGE_SKID_EN (registered in_ready, occupancy 0..2).
//
// Ports:
//   clk        stage clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous flush, drops every held beat and any beat offered this cycle
//   in_valid   upstream beat present on data_in
//   in_ready   stage can accept a beat this cycle
//   data_in    upstream payload
//   out_valid  data_out holds a valid beat
//   out_ready  downstream accepts data_out this cycle
//   data_out   main entry payload, FLUSH_VALUE when empty
//   occupancy  number of held beats
module pipe_stage_buffer #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign data_out = main_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides any fire in the same cycle
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) state_d = ONE;
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
`ifdef PIPE_STAGE_SKID_EN
                        state_d = FULL;
`else
                        state_d = ONE;
`endif
                    end else if (out_fire && !in_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output decode
    always_comb begin
        out_valid = (state_q != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
        occupancy = state_q;
        // Pure register decode: back-pressure never ripples upstream
        in_ready  = (state_q != FULL);
`else
        occupancy = {1'b0, state_q[0]};
        in_ready  = (state_q == EMPTY) | out_ready;
`endif
    end

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_WIDTH-1:0] skid_q;

    // Skid captures the beat accepted while downstream is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q <= FLUSH_VALUE;
        end else if (flush) begin
            skid_q <= FLUSH_VALUE;
        end else if (state_q == ONE && in_fire && !out_fire) begin
            skid_q <= data_in;
        end
    end
`endif

    // Main entry: reloads on pass-through, refills from skid, clears when drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= FLUSH_VALUE;
        end else if (flush) begin
            main_q <= FLUSH_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) main_q <= data_in;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= data_in;
                    end else if (out_fire) begin
                        main_q <= FLUSH_VALUE;
                    end
                end
                FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (out_fire) main_q <= skid_q;
`else
                    main_q <= FLUSH_VALUE;
`endif
                end
                default: main_q <= FLUSH_VALUE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: random + directed check of pipe_stage_buffer
// against a queue-based model of the stage.
module tb_pipe_stage_buffer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic [1:0]   occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] mq[$];
    logic         pend = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_WIDTH(W), .FLUSH_VALUE('0)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    function automatic logic m_in_ready(input logic ordy);
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || ordy;
    endfunction

    // One cycle: drive after negedge, check outputs, advance model on posedge
    task automatic step(input logic iv, input logic [W-1:0] d,
                        input logic ordy, input logic fl);
        logic exp_ir;
        logic ifire;
        logic ofire;
        @(negedge clk);
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ir = m_in_ready(ordy);
        chk("out_valid", W'(out_valid), W'(mq.size() != 0));
        chk("data_out", data_out, (mq.size() != 0) ? mq[0] : '0);
        chk("occupancy", W'(occupancy), W'(mq.size()));
        chk("in_ready", W'(in_ready), W'(exp_ir));
        ifire = iv && exp_ir;
        ofire = (mq.size() != 0) && ordy;
        pend  = iv && !exp_ir;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            pend = 1'b0;
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(d);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic         iv;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        #22;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_occupancy", W'(occupancy), '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));

        // Streaming with no bubbles
        step(1'b1, W'(64'h11), 1'b1, 1'b0);
        step(1'b1, W'(64'h22), 1'b1, 1'b0);
        step(1'b1, W'(64'h33), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure then drain in order
        step(1'b1, W'(64'hA), 1'b0, 1'b0);
        step(1'b1, W'(64'hB), 1'b0, 1'b0);
        step(1'b1, W'(64'hC), 1'b0, 1'b0);
        step(1'b1, W'(64'hC), 1'b1, 1'b0);
        step(1'b1, W'(64'hC), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush with a beat offered in the same cycle
        step(1'b1, W'(64'hA), 1'b0, 1'b0);
        step(1'b1, W'(64'hB), 1'b0, 1'b0);
        step(1'b1, W'(64'hD), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Drain a single beat to empty
        step(1'b1, W'(64'h55), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // No-skid style stall then replace in one edge
        step(1'b1, W'(64'h66), 1'b0, 1'b0);
        step(1'b1, W'(64'h77), 1'b0, 1'b0);
        step(1'b1, W'(64'h77), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic honouring the hold-stable rule
        d = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend) begin
                iv = ($urandom_range(0, 3) != 0);
                d  = {$urandom, $urandom};
            end else begin
                iv = 1'b1;
            end
            step(iv, d, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset mid-cycle with the stage loaded
        step(1'b1, W'(64'hA1), 1'b0, 1'b0);
        step(1'b1, W'(64'hB2), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("amid_out_valid", W'(out_valid), '0);
        chk("amid_data_out", data_out, '0);
        chk("amid_occupancy", W'(occupancy), '0);
        mq.delete();
        pend = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("amid_in_ready", W'(in_ready), W'(1));
        step(1'b1, W'(64'hC3), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
